viterbi_decoder_k3: RTL and testbench
=====================================

Name: viterbi_decoder_k3

Overview:
Hard-decision Viterbi decoder for the K=3, rate-1/2 convolutional code (G1=7 octal on sym[1], G0=5 octal on sym[0]) produced by the team's encoder_k3 stage. It sits directly downstream of encoder_k3 and the channel, consuming one 2-bit symbol per valid cycle and emitting one decoded bit per symbol after a fixed traceback latency. It uses a 4-state trellis, add-compare-select with Hamming branch metrics, and register-exchange survivor storage.

Parameters:
TB_DEPTH, 15, survivor length in symbols (decode latency); legal range 5..32
PM_W, 6, path-metric width in bits; must satisfy 2^PM_W > INIT_PM + 2*TB_DEPTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
start  input  1  frame start; re-initialises metrics and fill count
sym_in  input  2  received symbol {c1,c0}, c1 = u^u1^u2, c0 = u^u2
sym_valid  input  1  sym_in accepted this cycle; the block is always ready
bit_out  output  1  decoded bit
bit_valid  output  1  one-cycle pulse qualifying bit_out
err_cnt  output  16  corrected-bit count (VITERBI_ERRCNT_EN builds only)

Behaviour:
- State s = {s1,s0} = {u(n-1), u(n-2)}. Input u moves to next state {u,s1}, with branch output {u^s1^s0, u^s0}.
- Reset (rst=0, async): PM[0]=0, PM[1..3]=INIT_PM (8); survivors=0; fill=0; bit_out=0; bit_valid=0; err_cnt=0.
- start=1: same initialisation, applied synchronously. If sym_valid is also high, that symbol is processed as symbol 0 of the new frame against the initialised metrics.
- Per accepted symbol:
  - Branch metric = Hamming distance (0..2) between sym_in and the expected output.
  - Each next state has two predecessors, {s1,0} and {s1,1}. It selects the smaller PM+BM. On a tie it takes the predecessor with s0=0.
  - New survivor = selected predecessor's survivor shifted left, with the LSB set to the decision bit u.
- Normalisation: every accepted symbol, the minimum of the four candidate metrics is subtracted from all four before the metrics are registered. Additions saturate at 2^PM_W-1.
- Output:
  - fill counts accepted symbols and saturates at TB_DEPTH.
  - When a symbol with index j >= TB_DEPTH-1 is accepted, the next cycle has bit_valid=1 and bit_out = MSB (oldest bit) of the survivor of the minimum-metric state. That bit is the estimate of u(j-TB_DEPTH+1).
  - Ties for the best state resolve to the lowest state index.
- Latency: the first bit appears 1 clock after the TB_DEPTH-th symbol. After that, one bit per symbol.
- No symbol accepted: all state holds and bit_valid=0.
- No flush: the sender appends 2 zero tail bits plus TB_DEPTH-1 padding symbols to recover the final bits.
- Reset mid-frame: partial output is discarded with no spurious bit_valid pulse.

Optional Feature:
Macro VITERBI_ERRCNT_EN.
- Defined: err_cnt accumulates each cycle's normalisation subtrahend, i.e. the growth of the best-path Hamming distance. It saturates at 16'hFFFF, is cleared by reset and start, and is registered with the metrics.
- Undefined: the err_cnt port and accumulator are absent, with no other behavioural change.

Decomposition:
- Shared package viterbi_k3_pkg:
  - NUM_STATES=4
  - INIT_PM=8
  - expected-branch-output function (state, u) -> 2 bits
  - predecessor-index function
- One sub-module, viterbi_acs_k3: two PM inputs, two BMs, two survivors in; selected PM, decision, and new survivor out. Instantiated 4 times.
- Best-state selection and output register stay in the top level.

Test Plan:
1. Reset, then bits 1,0,1,1,0,0 encoded as symbols 11,10,00,01,01,11, followed by 14 zero symbols (00) -> bit_valid first pulses 1 clock after symbol 15; bits out are 1,0,1,1,0,0 then zeros; err_cnt=0.
2. Same stream with symbol 3 corrupted 01->11 -> identical decoded bits; err_cnt=1.
3. 200 random bits through an encoder model, 0/1/2 errors per 10-symbol window, spaced at least 6 symbols apart -> zero bit mismatches. Throughout the run, all registered PM <= 2*TB_DEPTH and no PM reaches 2^PM_W-1.
4. sym_valid gaps: symbols fed with random idle cycles -> same decoded sequence as test 1; bit_valid never high on a cycle not following an accepted symbol.
5. start asserted with sym_valid on symbol 7 of a frame -> no bit_valid for the next TB_DEPTH-1 accepted symbols; the new frame decodes correctly; err_cnt restarts at 0.
6. rst pulsed low for 1 ns mid-frame between clock edges -> bit_valid=0 and bit_out=0 immediately; the next frame decodes correctly.

Source files
------------

// File: rtl/viterbi_k3_pkg.sv
// Shared constants and trellis helpers for the K=3 (7,5) hard-decision Viterbi decoder.
package viterbi_k3_pkg;

  localparam int NUM_STATES = 4;
  localparam int INIT_PM    = 8;

  // State is {u(n-1), u(n-2)}; output is {u^s1^s0, u^s0}.
  function automatic logic [1:0] branch_out(input logic [1:0] state, input logic u);
    return {u ^ state[1] ^ state[0], u ^ state[0]};
  endfunction

  // The two predecessors of a next state share s1 = next_state[0] and differ in s0.
  function automatic logic [1:0] pred_state(input logic [1:0] next_state, input logic s0);
    return {next_state[0], s0};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs_k3.sv
// Add-compare-select for one trellis state: saturating PM+BM, tie goes to the s0=0 predecessor,
// register-exchange survivor update with the state's input bit appended as LSB.
module viterbi_acs_k3 #(
  parameter int PM_W     = 6,
  parameter int TB_DEPTH = 15
) (
  input  logic [PM_W-1:0]     pm0,
  input  logic [PM_W-1:0]     pm1,
  input  logic [1:0]          bm0,
  input  logic [1:0]          bm1,
  input  logic [TB_DEPTH-1:0] surv0,
  input  logic [TB_DEPTH-1:0] surv1,
  input  logic                u,
  output logic [PM_W-1:0]     pm_sel,
  output logic                dec,
  output logic [TB_DEPTH-1:0] surv_out
);
  import viterbi_k3_pkg::*;

  localparam logic [PM_W:0] PM_MAX = {1'b0, {PM_W{1'b1}}};

  logic [PM_W:0]     sum0, sum1;
  logic [PM_W-1:0]   cand0, cand1;
  logic [TB_DEPTH-1:0] surv_sel;

  assign sum0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
  assign sum1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
  assign cand0 = (sum0 > PM_MAX) ? '1 : sum0[PM_W-1:0];
  assign cand1 = (sum1 > PM_MAX) ? '1 : sum1[PM_W-1:0];

  assign dec      = (cand1 < cand0);
  assign pm_sel   = dec ? cand1 : cand0;
  assign surv_sel = dec ? surv1 : surv0;
  assign surv_out = {surv_sel[TB_DEPTH-2:0], u};

endmodule

// File: rtl/viterbi_decoder_k3.sv
// K=3 rate-1/2 hard-decision Viterbi decoder, register-exchange survivors, TB_DEPTH symbols latency.
// Optional VITERBI_ERRCNT_EN adds err_cnt, the accumulated best-path Hamming distance.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  sym_in,
  input  logic        sym_valid,
  output logic        bit_out,
  output logic        bit_valid
`ifdef VITERBI_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);
  import viterbi_k3_pkg::*;

  localparam int FILL_W = $clog2(TB_DEPTH + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);
  localparam logic [FILL_W-1:0] EMIT_AT  = FILL_W'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0]   PM_INIT  = PM_W'(INIT_PM);

  logic [PM_W-1:0]       pm        [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv      [NUM_STATES];
  logic [FILL_W-1:0]     fill;
  logic [PM_W-1:0]       pm_base   [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_base [NUM_STATES];
  logic [PM_W-1:0]       cand      [NUM_STATES];
  logic [TB_DEPTH-1:0]   surv_next [NUM_STATES];
  logic [NUM_STATES-1:0] dec_unused;
  logic [FILL_W-1:0]     fill_base;
  logic [PM_W-1:0]       min_pm;
  logic [1:0]            best;
  logic                  emit;

  // start re-initialises combinationally so a symbol on the same cycle uses fresh metrics.
  always_comb begin
    for (int s = 0; s < NUM_STATES; s++) begin
      pm_base[s]   = start ? ((s == 0) ? '0 : PM_INIT) : pm[s];
      surv_base[s] = start ? '0 : surv[s];
    end
    fill_base = start ? '0 : fill;
  end

  for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
    localparam logic [1:0] NS = 2'(ns);
    localparam logic [1:0] P0 = pred_state(NS, 1'b0);
    localparam logic [1:0] P1 = pred_state(NS, 1'b1);

    logic [1:0] bm0, bm1;
    assign bm0 = hamming2(sym_in, branch_out(P0, NS[1]));
    assign bm1 = hamming2(sym_in, branch_out(P1, NS[1]));

    viterbi_acs_k3 #(
      .PM_W     (PM_W),
      .TB_DEPTH (TB_DEPTH)
    ) u_acs (
      .pm0      (pm_base[P0]),
      .pm1      (pm_base[P1]),
      .bm0      (bm0),
      .bm1      (bm1),
      .surv0    (surv_base[P0]),
      .surv1    (surv_base[P1]),
      .u        (NS[1]),
      .pm_sel   (cand[ns]),
      .dec      (dec_unused[ns]),
      .surv_out (surv_next[ns])
    );
  end

  // Strict less-than keeps the lowest state index on ties.
  always_comb begin
    min_pm = cand[0];
    best   = 2'd0;
    for (int s = 1; s < NUM_STATES; s++) begin
      if (cand[s] < min_pm) begin
        min_pm = cand[s];
        best   = 2'(s);
      end
    end
  end

  assign emit = sym_valid && (fill_base >= EMIT_AT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= (s == 0) ? '0 : PM_INIT;
        surv[s] <= '0;
      end
      fill      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else if (sym_valid) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= cand[s] - min_pm;
        surv[s] <= surv_next[s];
      end
      fill      <= (fill_base < FILL_MAX) ? fill_base + 1'b1 : fill_base;
      bit_valid <= emit;
      if (emit) begin
        bit_out <= surv_next[best][TB_DEPTH-1];
      end else if (start) begin
        bit_out <= 1'b0;
      end
    end else if (start) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        pm[s]   <= pm_base[s];
        surv[s] <= '0;
      end
      fill      <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
    end
  end

`ifdef VITERBI_ERRCNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, (start ? 16'h0000 : err_cnt)} + 17'(min_pm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (sym_valid) begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end else if (start) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Randomised self-checking bench: encoder model + "decoded bit equals transmitted bit" reference.
module tb_viterbi_decoder_k3;

  localparam int TB = 15;
  localparam int PMW = 6;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       bit_out;
  logic       bit_valid;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_cnt;
`endif

  viterbi_decoder_k3 #(
    .TB_DEPTH (TB),
    .PM_W     (PMW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
`ifdef VITERBI_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int rst_events = 0;
  int pulses = 0;
  bit pm_watch = 0;
  bit src_bits [0:1023];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Encoder straight from the code definition: c1 = u^u1^u2, c0 = u^u2.
  function automatic logic [1:0] enc_sym(input logic u, input logic u1, input logic u2);
    return {u ^ u1 ^ u2, u ^ u2};
  endfunction

  // Reference: every emitted bit for frame index j is the transmitted bit j-TB+1.
  initial begin : compare
    int  j;
    int  seen_rst;
    bit  exp_v;
    bit  exp_b;
    logic acc_v, acc_s;
    j = 0;
    seen_rst = 0;
    forever begin
      @(posedge clk);
      acc_v = sym_valid;
      acc_s = start;
      if (rst_events != seen_rst) begin
        seen_rst = rst_events;
        j = 0;
      end
      exp_v = 1'b0;
      exp_b = 1'b0;
      if (!rst) begin
        j = 0;
      end else if (acc_v) begin
        if (acc_s) j = 0;
        if (j >= TB - 1) begin
          exp_v = 1'b1;
          exp_b = src_bits[j-TB+1];
        end
        j++;
      end else if (acc_s) begin
        j = 0;
      end
      #1;
      if (rst) begin
        chk("bit_valid", 32'(bit_valid), 32'(exp_v));
        if (exp_v) chk("bit_out", 32'(bit_out), 32'(exp_b));
        if (bit_valid === 1'b1) pulses++;
        if (pm_watch) begin
          for (int s = 0; s < 4; s++) begin
            chk("pm_bound", 32'(dut.pm[s] <= PMW'(2 * TB)), 32'd1);
            chk("pm_unsat", 32'(dut.pm[s] != {PMW{1'b1}}), 32'd1);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_sym(input logic [1:0] s, input bit st);
    sym_in    = s;
    sym_valid = 1'b1;
    start     = st;
    @(negedge clk);
    sym_valid = 1'b0;
    start     = 1'b0;
    sym_in    = 2'(($urandom_range(0, 3)));
  endtask

  task automatic send_frame(input int n, input bit with_start, input int gapmax,
                            input int fix_idx, input logic [1:0] fix_mask,
                            input bit rand_err, output int nerr);
    logic u1, u2;
    logic [1:0] c;
    int next_err;
    u1 = 1'b0;
    u2 = 1'b0;
    nerr = 0;
    next_err = int'($urandom_range(0, 9));
    for (int k = 0; k < n; k++) begin
      c  = enc_sym(src_bits[k], u1, u2);
      u2 = u1;
      u1 = src_bits[k];
      if (k == fix_idx) begin
        c ^= fix_mask;
        nerr++;
      end
      if (rand_err && k == next_err) begin
        if (k < n - (TB + 1)) begin
          c ^= ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
          nerr++;
        end
        next_err = k + 6 + int'($urandom_range(0, 6));
      end
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
      send_sym(c, with_start && (k == 0));
    end
  endtask

  task automatic load_pattern();
    bit pat [6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 20; k++) src_bits[k] = (k < 6) ? pat[k] : 1'b0;
  endtask

  initial begin : driver
    int nerr;
    int p0;
    int exp_syms [6];
    logic u1, u2;
    logic [1:0] c;

    rst = 1'b0;
    start = 1'b0;
    sym_valid = 1'b0;
    sym_in = 2'b00;
    idle(3);
    chk("reset_bit_valid", 32'(bit_valid), 32'd0);
    chk("reset_bit_out", 32'(bit_out), 32'd0);
`ifdef VITERBI_ERRCNT_EN
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b1;
    idle(2);

    // Pin the encoder model against hand-encoded symbols 11,10,00,01,01,11.
    load_pattern();
    exp_syms = '{3, 2, 0, 1, 1, 3};
    u1 = 1'b0;
    u2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c  = enc_sym(src_bits[k], u1, u2);
      u2 = u1;
      u1 = src_bits[k];
      chk("enc_model", 32'(c), 32'(exp_syms[k]));
    end

    // Test 1: clean frame after reset.
    p0 = pulses;
    send_frame(20, 1'b0, 0, -1, 2'b00, 1'b0, nerr);
    idle(3);
    chk("t1_pulses", 32'(pulses - p0), 32'd6);
`ifdef VITERBI_ERRCNT_EN
    chk("t1_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Test 2: symbol 3 corrupted 01 -> 11.
    load_pattern();
    send_frame(20, 1'b1, 0, 3, 2'b10, 1'b0, nerr);
    idle(3);
`ifdef VITERBI_ERRCNT_EN
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Test 3: 200 random bits, tail + padding, sparse random errors.
    for (int k = 0; k < 200 + TB + 1; k++) src_bits[k] = (k < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
    pm_watch = 1'b1;
    p0 = pulses;
    send_frame(200 + TB + 1, 1'b1, 0, -1, 2'b00, 1'b1, nerr);
    idle(3);
    pm_watch = 1'b0;
    chk("t3_pulses", 32'(pulses - p0), 32'(200 + 2));
`ifdef VITERBI_ERRCNT_EN
    chk("t3_err_cnt", 32'(err_cnt), 32'(nerr));
`endif

    // Test 4: idle gaps between symbols.
    load_pattern();
    p0 = pulses;
    send_frame(20, 1'b1, 3, -1, 2'b00, 1'b0, nerr);
    idle(3);
    chk("t4_pulses", 32'(pulses - p0), 32'd6);

    // Test 5: restart on symbol 7 of a noisy frame.
    for (int k = 0; k < 7; k++) src_bits[k] = 1'($urandom_range(0, 1));
    send_frame(7, 1'b1, 0, 2, 2'b01, 1'b0, nerr);
    load_pattern();
    p0 = pulses;
    send_frame(20, 1'b1, 0, -1, 2'b00, 1'b0, nerr);
    idle(3);
    chk("t5_pulses", 32'(pulses - p0), 32'd6);
`ifdef VITERBI_ERRCNT_EN
    chk("t5_err_cnt", 32'(err_cnt), 32'd0);
`endif

    // Test 6: short async reset pulse mid-frame while a 1 is being presented.
    for (int k = 0; k < 20; k++) src_bits[k] = 1'b1;
    send_frame(20, 1'b1, 0, -1, 2'b00, 1'b0, nerr);
    chk("t6_pre_bit_out", 32'(bit_out), 32'd1);
    #2;
    rst = 1'b0;
    rst_events++;
    #1;
    chk("t6_rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("t6_rst_bit_out", 32'(bit_out), 32'd0);
`ifdef VITERBI_ERRCNT_EN
    chk("t6_rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b1;
    idle(2);
    load_pattern();
    p0 = pulses;
    send_frame(20, 1'b0, 0, -1, 2'b00, 1'b0, nerr);
    idle(3);
    chk("t6_pulses", 32'(pulses - p0), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
